gpio_frame_packer: RTL and testbench

//  Parametrised successor of the GPIO-switch transfer stage: snapshots CH_NUM switch inputs
//  on an acquisition trigger (or on input change), packs them CPW channels per data word,

---
 rtl/gpio_frame_packer_pkg.sv | 28 ++
 rtl/gpio_frame_packer_word_sel.sv | 41 ++++
 rtl/gpio_frame_packer.sv | 98 +++++++++
 tb/tb_gpio_frame_packer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_frame_packer_pkg.sv
// Shared types and frame-geometry helpers for the GPIO frame packer.
package gpio_pack_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  localparam logic [7:0] HDR_TAG_DEF = 8'hA5;

  // Wide enough for FRAME_LEN up to 65 (64 channels, one per word, plus header).
  localparam int unsigned IDX_W = 7;

  function automatic int unsigned cpw(input int unsigned word_w, input int unsigned field_w);
    return word_w / field_w;
  endfunction

  function automatic int unsigned nwords(input int unsigned ch_num, input int unsigned word_w,
                                         input int unsigned field_w);
    return (ch_num + cpw(word_w, field_w) - 1) / cpw(word_w, field_w);
  endfunction

  function automatic int unsigned frame_len(input int unsigned header_en, input int unsigned ch_num,
                                            input int unsigned word_w, input int unsigned field_w);
    return header_en + nwords(ch_num, word_w, field_w);
  endfunction

endpackage

// File: rtl/gpio_frame_packer_word_sel.sv
// Combinational frame word generator: header or packed channel word selected by idx.
module gpio_word_sel
  import gpio_pack_pkg::*;
#(
  parameter int unsigned CH_NUM    = 20,
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned FIELD_W   = 8,
  parameter int unsigned HEADER_EN = 1,
  parameter logic [7:0]  HDR_TAG   = HDR_TAG_DEF
) (
  input  logic [CH_NUM-1:0] snap,
  input  logic [7:0]        seq,
  input  logic [IDX_W-1:0]  idx,
  output logic [WORD_W-1:0] word
);

  localparam int unsigned CPW    = cpw(WORD_W, FIELD_W);
  localparam int unsigned NWORDS = nwords(CH_NUM, WORD_W, FIELD_W);
  localparam int unsigned NSLOTS = NWORDS * CPW;

  logic [NSLOTS-1:0] snap_pad;
  logic [WORD_W-1:0] acc [NWORDS+1];

  assign snap_pad = NSLOTS'(snap);
  assign acc[0]   = (HEADER_EN != 0 && idx == '0) ? WORD_W'({HDR_TAG, seq}) : '0;

  // One-hot AND-OR mux chain keeps every index constant at elaboration time.
  for (genvar j = 0; j < NWORDS; j++) begin : g_word
    logic [WORD_W-1:0] data;
    for (genvar s = 0; s < CPW; s++) begin : g_slot
      assign data[FIELD_W*(CPW-s)-1 -: FIELD_W] = FIELD_W'(snap_pad[j*CPW+s]);
    end
    if (WORD_W > CPW * FIELD_W) begin : g_pad
      assign data[WORD_W-1:CPW*FIELD_W] = '0;
    end
    assign acc[j+1] = acc[j] | ((idx == IDX_W'(j + HEADER_EN)) ? data : '0);
  end

  assign word = acc[NWORDS];

endmodule

// File: rtl/gpio_frame_packer.sv
// Snapshots switch inputs on a trigger and streams a header + packed data frame into a write FIFO.
module gpio_frame_packer
  import gpio_pack_pkg::*;
#(
  parameter int unsigned CH_NUM    = 20,
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned FIELD_W   = 8,
  parameter int unsigned HEADER_EN = 1,
  parameter logic [7:0]  HDR_TAG   = HDR_TAG_DEF
) (
  input  logic              sys_clk_100m,
  input  logic              rst_n_i,
  input  logic [CH_NUM-1:0] gpio_switch,
  input  logic              adc_acq_start_pluse,
  input  logic              mode_i,
  input  logic              wr_full_i,
  output logic [WORD_W-1:0] wr_dout_o,
  output logic              wr_en_o,
  output logic              busy_o,
  output logic [15:0]       drop_cnt_o
);

  localparam int unsigned    FRAME_LEN = frame_len(HEADER_EN, CH_NUM, WORD_W, FIELD_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [7:0]         seq;
  logic [CH_NUM-1:0]  snap;
  logic [CH_NUM-1:0]  last_sent;
  logic [WORD_W-1:0]  word;
  logic               trig;

  assign trig = adc_acq_start_pluse | (mode_i & (gpio_switch != last_sent));

  gpio_word_sel #(
    .CH_NUM   (CH_NUM),
    .WORD_W   (WORD_W),
    .FIELD_W  (FIELD_W),
    .HEADER_EN(HEADER_EN),
    .HDR_TAG  (HDR_TAG)
  ) u_word_sel (
    .snap(snap),
    .seq (seq),
    .idx (idx),
    .word(word)
  );

  always_ff @(posedge sys_clk_100m or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      idx        <= '0;
      seq        <= '0;
      snap       <= '0;
      last_sent  <= '0;
      wr_dout_o  <= '0;
      wr_en_o    <= 1'b0;
      busy_o     <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          wr_en_o   <= 1'b0;
          wr_dout_o <= '0;
          if (trig) begin
            snap      <= gpio_switch;
            last_sent <= gpio_switch;
            idx       <= '0;
            busy_o    <= 1'b1;
            state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (trig && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 16'd1;
          if (!wr_full_i) begin
            wr_en_o   <= 1'b1;
            wr_dout_o <= word;
            idx       <= idx + IDX_W'(1);
            if (HEADER_EN != 0 && idx == '0) seq <= seq + 8'd1;
            if (idx == LAST_IDX) begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
            end
          end else begin
            wr_en_o <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          wr_en_o   <= 1'b0;
          wr_dout_o <= '0;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_frame_packer.sv
// Scoreboard bench for gpio_frame_packer: default build plus a 5-channel, headerless build.
module tb_gpio_frame_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] gpio;
  logic        pulse, mode, full;
  logic [15:0] dout;
  logic        wr_en, busy;
  logic [15:0] drop;

  logic [4:0]  gpio5;
  logic        pulse5;
  logic        mode5 = 1'b0;
  logic        full5 = 1'b0;
  logic [15:0] dout5;
  logic        wr_en5, busy5;
  logic [15:0] drop5;

  typedef struct packed {
    logic [15:0] w;
    logic        last;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       exp5_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_seq;

  always #5 clk = ~clk;

  gpio_frame_packer u_dut (
    .sys_clk_100m       (clk),
    .rst_n_i            (rst_n),
    .gpio_switch        (gpio),
    .adc_acq_start_pluse(pulse),
    .mode_i             (mode),
    .wr_full_i          (full),
    .wr_dout_o          (dout),
    .wr_en_o            (wr_en),
    .busy_o             (busy),
    .drop_cnt_o         (drop)
  );

  gpio_frame_packer #(
    .CH_NUM   (5),
    .WORD_W   (16),
    .FIELD_W  (4),
    .HEADER_EN(0)
  ) u_dut5 (
    .sys_clk_100m       (clk),
    .rst_n_i            (rst_n),
    .gpio_switch        (gpio5),
    .adc_acq_start_pluse(pulse5),
    .mode_i             (mode5),
    .wr_full_i          (full5),
    .wr_dout_o          (dout5),
    .wr_en_o            (wr_en5),
    .busy_o             (busy5),
    .drop_cnt_o         (drop5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Default build: header {A5, seq}, then two channels per word, even channel in the high byte.
  function automatic logic [15:0] model_word(input logic [19:0] g, input int i, input logic [7:0] sq);
    logic [19:0] sh;
    if (i == 0) return {8'hA5, sq};
    sh = g >> (2 * (i - 1));
    return {7'b0, sh[0], 7'b0, sh[1]};
  endfunction

  initial forever begin
    @(negedge clk);
    if (rst_n && wr_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got %h expected no write", dout);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("frame_word", 32'(dout), 32'(e.w));
        check("busy_with_write", 32'(busy), 32'(!e.last));
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && wr_en5) begin
      if (exp5_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write5: got %h expected no write", dout5);
      end else begin
        exp_t e;
        e = exp5_q.pop_front();
        check("frame_word5", 32'(dout5), 32'(e.w));
        check("busy_with_write5", 32'(busy5), 32'(!e.last));
      end
    end
  end

  // Drives one frame on the default DUT; called and returns on a falling edge.
  // Iteration c drives the inputs seen by rising edge E_c, then samples its result.
  task automatic run_frame(input logic [19:0] g, input bit use_pulse, input int stall_at,
                           input int stall_len, input logic [31:0] drop_at, input int flip_at);
    int writes = 0;
    int gaps   = 0;
    for (int i = 0; i < 11; i++) exp_q.push_back('{w: model_word(g, i, exp_seq), last: (i == 10)});
    exp_seq++;
    for (int c = 0; c < 200; c++) begin
      if (c == 0) gpio = g;
      if (c == flip_at) gpio = ~g;
      pulse = (c == 0 && use_pulse) || (c < 32 && drop_at[c[4:0]]);
      full  = (c >= stall_at + 1) && (c <= stall_at + stall_len);
      @(negedge clk);
      if (c == 0) begin
        check("busy_after_trigger", 32'(busy), 32'd1);
        check("no_write_at_trigger", 32'(wr_en), 32'd0);
      end
      if (wr_en) writes++;
      else if (writes > 0) gaps++;
      if (writes == 11) break;
    end
    pulse = 1'b0;
    full  = 1'b0;
    check("frame_write_count", 32'(writes), 32'd11);
    check("stall_gap_cycles", 32'(gaps), 32'(stall_len));
  endtask

  initial begin
    int act;
    int w5;
    rst_n  = 1'b0;
    gpio   = '0;
    pulse  = 1'b0;
    mode   = 1'b0;
    full   = 1'b0;
    gpio5  = '0;
    pulse5 = 1'b0;
    exp_seq = '0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_wr_en5", 32'(wr_en5), 32'd0);
    rst_n = 1'b1;

    // Two set channels, clean frame.
    run_frame(20'h00003, 1'b1, 0, 0, 32'h0, -1);
    check("drop_after_t1", 32'(drop), 32'd0);

    // Back-pressure on word 4 for three cycles.
    run_frame(20'hF0F0F, 1'b1, 4, 3, 32'h0, -1);

    // Dropped pulses (including the last-word cycle) and a mid-frame gpio change.
    run_frame(20'h00003, 1'b1, 0, 0, 32'h0000_0824, 3);
    check("drop_count", 32'(drop), 32'd3);

    // Change-triggered frame starting with no idle gap, then nothing while static.
    mode = 1'b1;
    run_frame(20'h80003, 1'b0, 0, 0, 32'h0, -1);
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (wr_en || busy) act++;
    end
    check("static_no_frame", 32'(act), 32'd0);
    check("drop_after_change", 32'(drop), 32'd3);
    mode = 1'b0;

    // Narrow-field headerless build.
    gpio5  = 5'b10110;
    pulse5 = 1'b1;
    exp5_q.push_back('{w: 16'h0110, last: 1'b0});
    exp5_q.push_back('{w: 16'h1000, last: 1'b1});
    w5 = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      pulse5 = 1'b0;
      if (wr_en5) w5++;
      if (w5 == 2) break;
    end
    check("frame5_write_count", 32'(w5), 32'd2);

    // Reset in the middle of a frame.
    gpio  = 20'h00003;
    pulse = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back('{w: model_word(20'h00003, i, exp_seq), last: 1'b0});
    act = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      pulse = 1'b0;
      if (wr_en) act++;
      if (act == 4) break;
    end
    check("pre_reset_writes", 32'(act), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_wr_en", 32'(wr_en), 32'd0);
    check("async_rst_dout", 32'(dout), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_drop", 32'(drop), 32'd0);
    check("pending_before_reset", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    exp_seq = '0;
    run_frame(20'hAAAAA, 1'b1, 0, 0, 32'h0, -1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("scoreboard5_empty", 32'(exp5_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
